// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth sequencer.
// Holds the FSM state enum, the Booth digit encoding, default sizing
// localparams and the window-to-digit decode used by the encoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit 2 marks a negative digit, bit 1 marks a doubled magnitude.
    typedef enum logic [2:0] {
        ZERO = 3'b000,
        POS1 = 3'b001,
        POS2 = 3'b010,
        NEG1 = 3'b101,
        NEG2 = 3'b110
    } digit_t;

    // Sizing at the default operand width.
    localparam int DEF_WIDTH = 16;
    localparam int ITER      = DEF_WIDTH / 2;
    localparam int CNT_W     = $clog2(ITER);

    // Sizing for an arbitrary even width >= 4.
    function automatic int iter_of(input int width);
        return width / 2;
    endfunction

    function automatic int cnt_w_of(input int width);
        return $clog2(width / 2);
    endfunction

    // Window is {B[2i+1], B[2i], B[2i-1]}.
    function automatic digit_t booth_decode(input logic [2:0] win);
        case (win)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Purpose: turn one radix-4 Booth window into a sign-extended, shifted partial product.
// Latency: purely combinational.
// Ports: win (3-bit window), a (multiplicand), neg_a (-A at WIDTH+1 bits), shift (digit index), pp (2*WIDTH partial product).
module booth_r4_encoder
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CW    = 3
) (
    input  logic [2:0]         win,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH:0]     neg_a,
    input  logic [CW-1:0]      shift,
    output logic [2*WIDTH-1:0] pp
);

    // One guard bit beyond WIDTH+1: -2A for A = -2^(WIDTH-1) equals +2^WIDTH,
    // which only fits as a positive value at WIDTH+2 signed bits.
    localparam int MW = WIDTH + 2;

    logic [MW-1:0]      mag;
    logic [2*WIDTH-1:0] ext;
    logic [CW:0]        sh2;

    always_comb begin
        mag = '0;
        case (booth_decode(win))
            POS1:    mag = {{2{a[WIDTH-1]}}, a};
            POS2:    mag = {a[WIDTH-1], a, 1'b0};
            NEG1:    mag = {neg_a[WIDTH], neg_a};
            NEG2:    mag = {neg_a, 1'b0};
            default: mag = '0;
        endcase
        ext = {{(2*WIDTH-MW){mag[MW-1]}}, mag};
        sh2 = {shift, 1'b0};
        pp  = ext << sh2;
    end

endmodule

// File: rtl/booth_r4_sequencer.sv
// Purpose: radix-4 Booth multiply sequencer feeding an external adder (acc_o + pp_o -> sum_i).
// Latency: WIDTH/2 cycles from accepted start to done; start held in DONE restarts immediately.
// Ports: start/a_i/b_i request (ignored while busy), acc_o/pp_o/sum_i adder loop, busy/done/product status.
module booth_r4_sequencer
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] pp_o,
    input  logic [2*WIDTH-1:0] sum_i,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int             N_ITER  = iter_of(WIDTH);
    localparam int             CW      = cnt_w_of(WIDTH);
    localparam logic [CW-1:0]  LAST    = CW'(N_ITER - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

    state_t state_q, state_d;
    logic   accept;
    logic   last;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH:0]     neg_a_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] product_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     b_sh;
    logic [2:0]         win;
    logic [2*WIDTH-1:0] pp;

    // Appending B[-1]=0 lets window i start at bit 2i of b_ext.
    assign b_ext = {b_q, 1'b0};
    assign b_sh  = b_ext >> {cnt_q, 1'b0};
    assign win   = b_sh[2:0];

    booth_r4_encoder #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_enc (
        .win   (win),
        .a     (a_q),
        .neg_a (neg_a_q),
        .shift (cnt_q),
        .pp    (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            neg_a_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else if (accept) begin
            a_q     <= a_i;
            b_q     <= b_i;
            // Negation at WIDTH+1 bits so -(-2^(WIDTH-1)) stays exact.
            neg_a_q <= ~{a_i[WIDTH-1], a_i} + ONE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            acc_q <= sum_i;
            cnt_q <= cnt_q + CNT_ONE;
            if (last) begin
                product_q <= sum_i;
            end
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign pp_o    = busy ? pp : '0;
    assign acc_o   = acc_q;
    assign product = product_q;

endmodule
